// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;
  localparam int unsigned COUNT_W = 16;

  // A PC may be fetched only when word-aligned and inside the populated ROM.
  function automatic logic pc_fetchable(input logic [31:0] pc, input int unsigned depth);
    return (pc[1:0] == 2'b00) && ({2'b00, pc[31:2]} < depth);
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output register holding one fetched {pc, inst} pair for decode.
module fetch_out_reg (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic        ready_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  // Flush wins over load; a load replaces the entry even while it is being accepted.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      inst_d  = inst_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output stage storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, addresses the ROM, registers fetches
// for decode, applies execute redirects and halts on an unfetchable PC.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned ROM_DEPTH = 20,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [31:0]        rom_inst,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_inst,
  output logic [31:0]        out_pc,
  output logic               halted,
  output logic [COUNT_W-1:0] fetch_count
);

  fetch_state_e        state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic                load;
  logic                flush;
  logic                slot_free;
  logic                accept;

  assign slot_free = !out_valid || out_ready;
  assign accept    = out_valid && out_ready;

  // Next state / PC: redirect first, then fetch attempt when the output slot frees.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      FS_IDLE: begin
        if (fetch_en) state_d = FS_RUN;
      end
      FS_RUN: begin
        if (redirect_valid) begin
          pc_d  = redirect_pc;
          flush = 1'b1;
        end else if (fetch_en && slot_free) begin
          if (pc_fetchable(pc_q, ROM_DEPTH)) begin
            load = 1'b1;
            pc_d = pc_q + PC_STEP;
          end else begin
            state_d = FS_HALT;
          end
        end
      end
      FS_HALT: begin
        state_d = FS_HALT;
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase
  end

  // Saturating count of handshakes with decode, including one coinciding with a flush.
  always_comb begin
    count_d = count_q;
    if (accept && (count_q != '1)) count_d = count_q + 1'b1;
  end

  // State, PC and counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  fetch_out_reg u_out_reg (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .load_i  (load),
    .flush_i (flush),
    .ready_i (out_ready),
    .pc_i    (pc_q),
    .inst_i  (rom_inst),
    .valid_o (out_valid),
    .pc_o    (out_pc),
    .inst_o  (out_inst)
  );

  assign rom_addr    = pc_q[ADDR_W+1:2];
  assign halted      = (state_q == FS_HALT);
  assign fetch_count = count_q;

endmodule
